// File: rtl/if_id_stall_pipe.sv
// ---------------------------------------------------------------------------
// if_id_stall_pipe
//
// Consumer side of the load-use hazard interface. Holds the program counter,
// the IF/ID pipeline register and the control-bubble mux that feeds ID/EX.
// The hazard detection unit asks for a hold through PCWrite/IFIDWrite
// (1 = hold). The branch unit in ID kills the fetched instruction with flush.
// The block also keeps a saturating count of held cycles and a sticky
// watchdog flag that sets when a stall goes on for too long.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   PCWrite        1 = hold the PC this cycle
//   IFIDWrite      1 = hold the IF/ID register this cycle
//   flush          taken branch/jump in ID: load branch_target, kill fetch
//   branch_target  PC to load on flush
//   instr_in       instruction memory data for pc_out
//   ctrl_in        main control output for the instruction in ID
//   pc_out         current PC (instruction memory address)
//   ifid_instr     instruction registered in ID
//   ifid_pc4       PC+4 of the instruction in ID
//   ifid_valid     ID holds a real, non-killed instruction
//   ifid_rs        ifid_instr[25:21], back to the hazard unit
//   ifid_rt        ifid_instr[20:16], back to the hazard unit
//   idex_ctrl      registered control bundle into ID/EX (0 = bubble)
//   stall_count    total held cycles since reset, saturating
//   stall_err      sticky stuck-stall watchdog flag
// ---------------------------------------------------------------------------
module if_id_stall_pipe #(
  parameter int unsigned         PC_WIDTH    = 32,
  parameter int unsigned         INSTR_WIDTH = 32,
  parameter int unsigned         CTRL_WIDTH  = 9,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned         MAX_STALL   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   PCWrite,
  input  logic                   IFIDWrite,
  input  logic                   flush,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic [CTRL_WIDTH-1:0]  ctrl_in,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [INSTR_WIDTH-1:0] ifid_instr,
  output logic [PC_WIDTH-1:0]    ifid_pc4,
  output logic                   ifid_valid,
  output logic [4:0]             ifid_rs,
  output logic [4:0]             ifid_rt,
  output logic [CTRL_WIDTH-1:0]  idex_ctrl,
  output logic [15:0]            stall_count,
  output logic                   stall_err
);

  // Run-length counter only needs to reach MAX_STALL+1, where it saturates.
  localparam int unsigned    RL_W   = $clog2(MAX_STALL + 2);
  localparam logic [RL_W-1:0] RL_MAX = RL_W'(MAX_STALL + 1);
  localparam logic [RL_W-1:0] RL_ONE = RL_W'(1);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } stall_state_t;

  logic                   hold;
  logic                   take_flush;
  logic [PC_WIDTH-1:0]    pc_q;
  logic [PC_WIDTH-1:0]    pc_d;
  logic [PC_WIDTH-1:0]    pc_plus4;
  logic [INSTR_WIDTH-1:0] ifid_instr_q;
  logic [INSTR_WIDTH-1:0] ifid_instr_d;
  logic [PC_WIDTH-1:0]    ifid_pc4_q;
  logic [PC_WIDTH-1:0]    ifid_pc4_d;
  logic                   ifid_valid_q;
  logic                   ifid_valid_d;
  logic [CTRL_WIDTH-1:0]  idex_ctrl_q;
  logic [CTRL_WIDTH-1:0]  idex_ctrl_d;
  logic [15:0]            stall_count_q;
  logic [15:0]            stall_count_d;
  logic                   stall_err_q;
  logic                   err_set;
  stall_state_t           state_q;
  stall_state_t           state_d;
  logic [RL_W-1:0]        run_len_q;
  logic [RL_W-1:0]        run_len_d;

  assign hold       = PCWrite | IFIDWrite;
  // A flush seen during a hold uses stale branch operands; the branch
  // resolves again once the stall is over, so it is simply dropped here.
  assign take_flush = flush & ~hold;
  assign pc_plus4   = pc_q + PC_WIDTH'(4);

  // Next PC: hold beats flush beats sequential advance. A hold asked only on
  // IF/ID still lets the PC advance.
  always_comb begin
    pc_d = pc_plus4;
    if (PCWrite) begin
      pc_d = pc_q;
    end else if (take_flush) begin
      pc_d = branch_target;
    end
  end

  // Next IF/ID contents. A hold asked only on the PC still reloads IF/ID.
  always_comb begin
    ifid_instr_d = instr_in;
    ifid_pc4_d   = pc_plus4;
    ifid_valid_d = 1'b1;
    if (IFIDWrite) begin
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
    end else if (take_flush) begin
      ifid_instr_d = '0;
      ifid_pc4_d   = '0;
      ifid_valid_d = 1'b0;
    end
  end

  // Any hold turns the ID/EX slot into a bubble. A killed IF/ID slot also
  // becomes a bubble, while a flushing branch itself still moves on.
  always_comb begin
    idex_ctrl_d = '0;
    if (!hold && ifid_valid_q) begin
      idex_ctrl_d = ctrl_in;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (hold && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  // Stall tracker. The run length counts every held edge of the current
  // stall, the entry edge included, so the flag sets on held edge
  // MAX_STALL+1.
  always_comb begin
    state_d   = state_q;
    run_len_d = run_len_q;
    err_set   = 1'b0;
    case (state_q)
      RUN: begin
        run_len_d = '0;
        if (hold) begin
          state_d   = STALL;
          run_len_d = RL_ONE;
        end
      end
      STALL: begin
        if (hold) begin
          if (run_len_q != RL_MAX) begin
            run_len_d = run_len_q + RL_ONE;
          end
        end else begin
          state_d   = RUN;
          run_len_d = '0;
        end
      end
      default: begin
        state_d   = RUN;
        run_len_d = '0;
      end
    endcase
    if (run_len_d == RL_MAX) begin
      err_set = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      run_len_q <= '0;
    end else begin
      state_q   <= state_d;
      run_len_q <= run_len_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      ifid_instr_q  <= '0;
      ifid_pc4_q    <= '0;
      ifid_valid_q  <= 1'b0;
      idex_ctrl_q   <= '0;
      stall_count_q <= '0;
      stall_err_q   <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc4_q    <= ifid_pc4_d;
      ifid_valid_q  <= ifid_valid_d;
      idex_ctrl_q   <= idex_ctrl_d;
      stall_count_q <= stall_count_d;
      stall_err_q   <= stall_err_q | err_set;
    end
  end

  assign pc_out      = pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_pc4    = ifid_pc4_q;
  assign ifid_valid  = ifid_valid_q;
  assign ifid_rs     = ifid_instr_q[25:21];
  assign ifid_rt     = ifid_instr_q[20:16];
  assign idex_ctrl   = idex_ctrl_q;
  assign stall_count = stall_count_q;
  assign stall_err   = stall_err_q;

endmodule

// File: tb/tb_if_id_stall_pipe.sv
// ---------------------------------------------------------------------------
// tb_if_id_stall_pipe
//
// Self-checking bench for if_id_stall_pipe. The directed scenarios follow the
// hazard interface use cases. A randomized run is compared cycle by cycle
// against a behavioural model of the pipeline front end.
// ---------------------------------------------------------------------------
module tb_if_id_stall_pipe;

  localparam int MAX_STALL = 4;

  logic        clk;
  logic        rst_n;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        flush;
  logic [31:0] branch_target;
  logic [31:0] instr_in;
  logic [8:0]  ctrl_in;
  logic [31:0] pc_out;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [4:0]  ifid_rs;
  logic [4:0]  ifid_rt;
  logic [8:0]  idex_ctrl;
  logic [15:0] stall_count;
  logic        stall_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the architectural state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic [8:0]  m_ctrl;
  int          m_count;
  int          m_run;
  logic        m_err;

  if_id_stall_pipe #(
    .PC_WIDTH   (32),
    .INSTR_WIDTH(32),
    .CTRL_WIDTH (9),
    .RESET_PC   (32'h0),
    .MAX_STALL  (MAX_STALL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PCWrite      (PCWrite),
    .IFIDWrite    (IFIDWrite),
    .flush        (flush),
    .branch_target(branch_target),
    .instr_in     (instr_in),
    .ctrl_in      (ctrl_in),
    .pc_out       (pc_out),
    .ifid_instr   (ifid_instr),
    .ifid_pc4     (ifid_pc4),
    .ifid_valid   (ifid_valid),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .idex_ctrl    (idex_ctrl),
    .stall_count  (stall_count),
    .stall_err    (stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
    m_ctrl  = 9'h0;
    m_count = 0;
    m_run   = 0;
    m_err   = 1'b0;
  endtask

  // One clock edge of the front end, written from the hold/flush rules.
  task automatic model_step();
    logic        hold;
    logic [31:0] old_pc;
    logic        old_valid;
    hold      = PCWrite || IFIDWrite;
    old_pc    = m_pc;
    old_valid = m_valid;
    if (PCWrite)            m_pc = old_pc;
    else if (hold || !flush) m_pc = old_pc + 32'd4;
    else                    m_pc = branch_target;
    if (!IFIDWrite) begin
      if (!hold && flush) begin
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
      end else begin
        m_instr = instr_in;
        m_pc4   = old_pc + 32'd4;
        m_valid = 1'b1;
      end
    end
    m_ctrl = (!hold && old_valid) ? ctrl_in : 9'h0;
    if (hold) begin
      if (m_count < 65535) m_count = m_count + 1;
      m_run = m_run + 1;
      if (m_run > MAX_STALL) m_err = 1'b1;
    end else begin
      m_run = 0;
    end
  endtask

  task automatic applyStimulus(input logic pcw, input logic ifw, input logic fl,
                               input logic [31:0] bt, input logic [31:0] instr,
                               input logic [8:0] ctrl);
    PCWrite       = pcw;
    IFIDWrite     = ifw;
    flush         = fl;
    branch_target = bt;
    instr_in      = instr;
    ctrl_in       = ctrl;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    PCWrite       = 1'b0;
    IFIDWrite     = 1'b0;
    flush         = 1'b0;
    branch_target = 32'h0;
    instr_in      = 32'h0;
    ctrl_in       = 9'h0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (pc_out !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_pc: got %h expected %h", pc_out, 32'h0);
    end
    n_checks++;
    if ({ifid_instr, ifid_pc4, ifid_valid} !== 65'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_ifid: got instr=%h pc4=%h valid=%b expected all zero",
               ifid_instr, ifid_pc4, ifid_valid);
    end
    n_checks++;
    if ({ifid_rs, ifid_rt, idex_ctrl, stall_count, stall_err} !== 36'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_misc: got rs=%h rt=%h ctrl=%h cnt=%0d err=%b expected all zero",
               ifid_rs, ifid_rt, idex_ctrl, stall_count, stall_err);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    logic [31:0] instrs [3];
    logic [8:0]  ctrls  [3];
    instrs[0] = 32'h8C22_0004;
    instrs[1] = 32'h0043_1820;
    instrs[2] = 32'h00A6_3822;
    ctrls[0]  = 9'h1A3;
    ctrls[1]  = 9'h0C5;
    ctrls[2]  = 9'h13E;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, instrs[i], ctrls[i]);
      exp_pc = 32'd4 * (i + 1);
      n_checks++;
      if (pc_out !== exp_pc) begin
        n_fail++;
        $display("[TB] FAIL seq_pc[%0d]: got %h expected %h", i, pc_out, exp_pc);
      end
      n_checks++;
      if (idex_ctrl !== ((i == 0) ? 9'h0 : ctrls[i])) begin
        n_fail++;
        $display("[TB] FAIL seq_ctrl[%0d]: got %h expected %h", i, idex_ctrl,
                 (i == 0) ? 9'h0 : ctrls[i]);
      end
    end
    n_checks++;
    if (ifid_instr !== instrs[2] || ifid_pc4 !== 32'd12 || ifid_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL seq_ifid: got instr=%h pc4=%h valid=%b expected %h %h 1",
               ifid_instr, ifid_pc4, ifid_valid, instrs[2], 32'd12);
    end
    n_checks++;
    if (ifid_rs !== 5'd5 || ifid_rt !== 5'd6) begin
      n_fail++;
      $display("[TB] FAIL seq_rs_rt: got rs=%0d rt=%0d expected 5 6", ifid_rs, ifid_rt);
    end
  endtask

  task automatic test_single_hold();
    do_reset();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h1111_0000, 9'h011);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h2222_0000, 9'h022);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h3333_0000, 9'h033);
    n_checks++;
    if (pc_out !== 32'd8 || ifid_instr !== 32'h2222_0000) begin
      n_fail++;
      $display("[TB] FAIL hold_state: got pc=%h instr=%h expected 8 22220000", pc_out, ifid_instr);
    end
    n_checks++;
    if (idex_ctrl !== 9'h0 || stall_count !== 16'd1) begin
      n_fail++;
      $display("[TB] FAIL hold_bubble: got ctrl=%h cnt=%0d expected 0 1", idex_ctrl, stall_count);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h3333_0000, 9'h044);
    n_checks++;
    if (pc_out !== 32'd12 || ifid_instr !== 32'h3333_0000 || idex_ctrl !== 9'h044) begin
      n_fail++;
      $display("[TB] FAIL hold_resume: got pc=%h instr=%h ctrl=%h expected c 33330000 044",
               pc_out, ifid_instr, idex_ctrl);
    end
  endtask

  task automatic test_flush();
    do_reset();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'hAAAA_0001, 9'h001);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'hAAAA_0002, 9'h002);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h40, 32'hAAAA_0003, 9'h0B1);
    n_checks++;
    if (pc_out !== 32'h40 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL flush_kill: got pc=%h valid=%b instr=%h pc4=%h expected 40 0 0 0",
               pc_out, ifid_valid, ifid_instr, ifid_pc4);
    end
    n_checks++;
    if (idex_ctrl !== 9'h0B1) begin
      n_fail++;
      $display("[TB] FAIL flush_branch_ctrl: got %h expected %h", idex_ctrl, 9'h0B1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'hAAAA_0040, 9'h1FF);
    n_checks++;
    if (idex_ctrl !== 9'h0 || pc_out !== 32'h44 || ifid_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL flush_killed_slot: got ctrl=%h pc=%h valid=%b expected 0 44 1",
               idex_ctrl, pc_out, ifid_valid);
    end
  endtask

  task automatic test_flush_under_hold();
    do_reset();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'hBBBB_0001, 9'h001);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'hBBBB_0002, 9'h002);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h80, 32'hBBBB_0003, 9'h003);
    n_checks++;
    if (pc_out !== 32'd8 || ifid_instr !== 32'hBBBB_0002 || ifid_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL flush_ignored: got pc=%h instr=%h valid=%b expected 8 bbbb0002 1",
               pc_out, ifid_instr, ifid_valid);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h80, 32'hBBBB_0003, 9'h004);
    n_checks++;
    if (pc_out !== 32'h80 || ifid_valid !== 1'b0 || idex_ctrl !== 9'h004) begin
      n_fail++;
      $display("[TB] FAIL flush_retry: got pc=%h valid=%b ctrl=%h expected 80 0 004",
               pc_out, ifid_valid, idex_ctrl);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'hCCCC_0001, 9'h001);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'hCCCC_0002, 9'h002);
      n_checks++;
      if (stall_err !== ((i == 5) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("[TB] FAIL watchdog_edge[%0d]: got %b expected %b", i, stall_err, (i == 5));
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'hCCCC_0002, 9'h003);
    n_checks++;
    if (stall_err !== 1'b1 || stall_count !== 16'd5) begin
      n_fail++;
      $display("[TB] FAIL watchdog_sticky: got err=%b cnt=%0d expected 1 5", stall_err, stall_count);
    end
    // A four-cycle stall after a gap must not trip a fresh watchdog.
    do_reset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 9'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 9'h0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 9'h0);
    n_checks++;
    if (stall_err !== 1'b0 || stall_count !== 16'd8) begin
      n_fail++;
      $display("[TB] FAIL watchdog_runs: got err=%b cnt=%0d expected 0 8", stall_err, stall_count);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 9'h0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b1, 32'h60, 32'hDDDD_0000, 9'h055);
    n_checks++;
    if (pc_out !== 32'h20 || stall_err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midreset_setup: got pc=%h err=%b expected 20 1", pc_out, stall_err);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pc_out !== 32'h0 || idex_ctrl !== 9'h0 || stall_count !== 16'd0 ||
        stall_err !== 1'b0 || ifid_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midreset_async: got pc=%h ctrl=%h cnt=%0d err=%b valid=%b expected all zero",
               pc_out, idex_ctrl, stall_count, stall_err, ifid_valid);
    end
    do_reset();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'hEEEE_0000, 9'h0);
    n_checks++;
    if (pc_out !== 32'd4 || stall_count !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL midreset_resume: got pc=%h cnt=%0d expected 4 0", pc_out, stall_count);
    end
  endtask

  task automatic test_random();
    int          sel;
    logic        pcw;
    logic        ifw;
    logic        fl;
    logic [31:0] bt;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      sel = $urandom_range(0, 9);
      pcw = (sel <= 2);
      ifw = (sel <= 1) || (sel == 3);
      fl  = ($urandom_range(0, 4) == 0);
      bt  = $urandom & 32'hFFFF_FFFC;
      if (cyc == 200) bt = 32'hFFFF_FFFC;
      applyStimulus(pcw, ifw, fl, bt, $urandom, 9'($urandom));
      n_checks++;
      if (pc_out !== m_pc || ifid_instr !== m_instr || ifid_pc4 !== m_pc4 || ifid_valid !== m_valid) begin
        n_fail++;
        $display("[TB] FAIL rand_front[%0d]: got pc=%h instr=%h pc4=%h v=%b expected %h %h %h %b",
                 cyc, pc_out, ifid_instr, ifid_pc4, ifid_valid, m_pc, m_instr, m_pc4, m_valid);
      end
      n_checks++;
      if (ifid_rs !== m_instr[25:21] || ifid_rt !== m_instr[20:16]) begin
        n_fail++;
        $display("[TB] FAIL rand_rs_rt[%0d]: got %0d %0d expected %0d %0d",
                 cyc, ifid_rs, ifid_rt, m_instr[25:21], m_instr[20:16]);
      end
      n_checks++;
      if (idex_ctrl !== m_ctrl || stall_count !== 16'(m_count) || stall_err !== m_err) begin
        n_fail++;
        $display("[TB] FAIL rand_ctrl_stats[%0d]: got ctrl=%h cnt=%0d err=%b expected %h %0d %b",
                 cyc, idex_ctrl, stall_count, stall_err, m_ctrl, m_count, m_err);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_sequential();
    test_single_hold();
    test_flush();
    test_flush_under_hold();
    test_watchdog();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
